dna_codec_scheduler: RTL and testbench

Sequencing and arbitration controller for the shared BCH/DNA codec datapath. It owns the datapath's mode/operand/finish interface, accepts encode (write) requests carrying 39-bit messages and decode (read) requests carrying 40-nucleotide ASCII strands, and serialises them with round-robin arbitration. It guarantees the datapath's required idle gap between operations and returns each result on a valid/ready output channel. It also guards each operation with a timeout watchdog.

---
 rtl/dna_codec_scheduler.sv | 241 ++++++++++++++++++++++++
 tb/tb_dna_codec_scheduler.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dna_codec_scheduler.sv
// dna_codec_scheduler
// Serialises encode (write) and decode (read) requests onto the shared
// BCH/DNA codec datapath. Round-robin arbitration in IDLE, one ARM cycle
// that masks a stale dp_finish, a watchdog-guarded WAIT, a RESPOND stage
// that holds the result until it is taken, and a mode-0 GAP before the
// next operation.
//
// Handshake rule for every channel (wr, rd, enc, dec): a transfer happens
// on a rising clk edge where valid and ready are both high. A producer
// keeps valid and data stable until that edge. A consumer may raise or drop
// ready freely. wr_ready/rd_ready are combinational from the request valids
// and the IDLE state, and at most one of them is high.
//
// dbg_state exposes the FSM state: 0 IDLE, 1 ARM, 2 WAIT, 3 RESPOND, 4 GAP.

module dna_codec_scheduler #(
    parameter int MESSAGE_SIZE   = 39,
    parameter int DNA_WIDTH      = 320,
    parameter int GAP_CYCLES     = 1,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    resetN,
    // encode requests
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [MESSAGE_SIZE-1:0] wr_data,
    // decode requests
    input  logic                    rd_valid,
    output logic                    rd_ready,
    input  logic [DNA_WIDTH-1:0]    rd_data,
    // encode results
    output logic                    enc_valid,
    input  logic                    enc_ready,
    output logic [DNA_WIDTH-1:0]    enc_data,
    // decode results
    output logic                    dec_valid,
    input  logic                    dec_ready,
    output logic [MESSAGE_SIZE-1:0] dec_data,
    // datapath side
    output logic [1:0]              dp_mode,
    output logic [MESSAGE_SIZE-1:0] dp_write_in,
    output logic [DNA_WIDTH-1:0]    dp_read_in,
    input  logic [DNA_WIDTH-1:0]    dp_write_out,
    input  logic [MESSAGE_SIZE-1:0] dp_read_out,
    input  logic                    dp_finish,
    // status
    output logic                    busy,
    output logic                    timeout_err,
    output logic [15:0]             err_count,
    output logic [2:0]              dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_WAIT    = 3'd2,
        S_RESPOND = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    // Operation type encoding, also used for last_grant.
    localparam logic OP_WR = 1'b0;
    localparam logic OP_RD = 1'b1;

    localparam int               WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam int               GAP_W   = $clog2(GAP_CYCLES + 2);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam bit               HAS_GAP = (GAP_CYCLES > 0);

    state_t                  state_q, state_d;
    logic                    op_q, op_d;
    logic                    last_grant_q, last_grant_d;
    logic [WD_W-1:0]         wd_q, wd_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic [15:0]             err_q, err_d;
    logic [MESSAGE_SIZE-1:0] wr_op_q;
    logic [DNA_WIDTH-1:0]    rd_op_q;
    logic [DNA_WIDTH-1:0]    enc_res_q;
    logic [MESSAGE_SIZE-1:0] dec_res_q;

    logic idle;
    logic wr_win, rd_win;
    logic wr_fire, rd_fire;
    logic res_fire;
    logic load_wr, load_rd;
    logic load_enc, load_dec;
    logic timeout_pulse;

    // Arbitration: a lone request wins; on a tie the type not granted last wins.
    always_comb begin
        wr_win = wr_valid && (!rd_valid || (last_grant_q == OP_RD));
        rd_win = rd_valid && (!wr_valid || (last_grant_q == OP_WR));
    end

    // Readies are gated by reset so every output reads 0 while resetN is low.
    assign idle     = resetN && (state_q == S_IDLE);
    assign wr_ready = idle && wr_win;
    assign rd_ready = idle && rd_win;
    assign wr_fire  = wr_valid && wr_ready;
    assign rd_fire  = rd_valid && rd_ready;
    assign res_fire = (op_q == OP_WR) ? enc_ready : dec_ready;

    // Next-state, watchdog, gap counter and error counter logic.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        last_grant_d  = last_grant_q;
        wd_d          = wd_q;
        gap_d         = gap_q;
        err_d         = err_q;
        load_wr       = 1'b0;
        load_rd       = 1'b0;
        load_enc      = 1'b0;
        load_dec      = 1'b0;
        timeout_pulse = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wr_fire) begin
                    op_d         = OP_WR;
                    last_grant_d = OP_WR;
                    load_wr      = 1'b1;
                    state_d      = S_ARM;
                end else if (rd_fire) begin
                    op_d         = OP_RD;
                    last_grant_d = OP_RD;
                    load_rd      = 1'b1;
                    state_d      = S_ARM;
                end
            end
            S_ARM: begin
                // dp_finish may still be high from the previous operation.
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (dp_finish) begin
                    // Finish wins over a coinciding watchdog expiry.
                    load_enc = (op_q == OP_WR);
                    load_dec = (op_q == OP_RD);
                    state_d  = S_RESPOND;
                end else if (wd_q == WD_LAST) begin
                    timeout_pulse = 1'b1;
                    if (err_q != 16'hFFFF) begin
                        err_d = err_q + 16'd1;
                    end
                    gap_d   = '0;
                    state_d = HAS_GAP ? S_GAP : S_IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_RESPOND: begin
                if (res_fire) begin
                    gap_d   = '0;
                    state_d = HAS_GAP ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state registers; reset drops any in-flight operation.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= S_IDLE;
            op_q         <= OP_WR;
            last_grant_q <= OP_RD;
            wd_q         <= '0;
            gap_q        <= '0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            last_grant_q <= last_grant_d;
            wd_q         <= wd_d;
            gap_q        <= gap_d;
            err_q        <= err_d;
        end
    end

    // Operand registers: only the granted type's operand loads on accept.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_op_q <= '0;
            rd_op_q <= '0;
        end else begin
            if (load_wr) begin
                wr_op_q <= wr_data;
            end
            if (load_rd) begin
                rd_op_q <= rd_data;
            end
        end
    end

    // Result registers: capture the datapath output when finish is seen in WAIT.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            enc_res_q <= '0;
            dec_res_q <= '0;
        end else begin
            if (load_enc) begin
                enc_res_q <= dp_write_out;
            end
            if (load_dec) begin
                dec_res_q <= dp_read_out;
            end
        end
    end

    // Output decode from state.
    always_comb begin
        dp_mode = 2'd0;
        if ((state_q == S_ARM) || (state_q == S_WAIT)) begin
            dp_mode = (op_q == OP_RD) ? 2'd2 : 2'd1;
        end
    end

    assign enc_valid   = (state_q == S_RESPOND) && (op_q == OP_WR);
    assign dec_valid   = (state_q == S_RESPOND) && (op_q == OP_RD);
    assign enc_data    = enc_res_q;
    assign dec_data    = dec_res_q;
    assign dp_write_in = wr_op_q;
    assign dp_read_in  = rd_op_q;
    assign busy        = (state_q != S_IDLE);
    assign timeout_err = timeout_pulse;
    assign err_count   = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_dna_codec_scheduler.sv
// Directed testbench for dna_codec_scheduler. A small datapath model raises
// dp_finish a programmable number of cycles after dp_mode leaves 0. Inputs
// are driven and outputs sampled on the falling clock edge.

module tb_dna_codec_scheduler;

  localparam int MS = 39;
  localparam int DW = 320;

  localparam logic [MS-1:0] M1 = 39'h12_3456_789A;
  localparam logic [MS-1:0] M2 = 39'h55_AA55_AA55;
  localparam logic [DW-1:0] S1 = {10{32'h4143_4754}};
  localparam logic [DW-1:0] S2 = {10{32'h5447_4341}};

  logic          clk;
  logic          resetN;
  logic          wr_valid, wr_ready;
  logic [MS-1:0] wr_data;
  logic          rd_valid, rd_ready;
  logic [DW-1:0] rd_data;
  logic          enc_valid, enc_ready;
  logic [DW-1:0] enc_data;
  logic          dec_valid, dec_ready;
  logic [MS-1:0] dec_data;
  logic [1:0]    dp_mode;
  logic [MS-1:0] dp_write_in;
  logic [DW-1:0] dp_read_in;
  logic [DW-1:0] dp_write_out;
  logic [MS-1:0] dp_read_out;
  logic          dp_finish;
  logic          busy;
  logic          timeout_err;
  logic [15:0]   err_count;
  logic [2:0]    dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // datapath model controls
  bit model_en = 0;
  int model_delay = 5;
  bit dp_force = 0;
  int mcnt = 0;

  dna_codec_scheduler #(
    .MESSAGE_SIZE(MS),
    .DNA_WIDTH(DW),
    .GAP_CYCLES(1),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_data(wr_data),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .rd_data(rd_data),
    .enc_valid(enc_valid),
    .enc_ready(enc_ready),
    .enc_data(enc_data),
    .dec_valid(dec_valid),
    .dec_ready(dec_ready),
    .dec_data(dec_data),
    .dp_mode(dp_mode),
    .dp_write_in(dp_write_in),
    .dp_read_in(dp_read_in),
    .dp_write_out(dp_write_out),
    .dp_read_out(dp_read_out),
    .dp_finish(dp_finish),
    .busy(busy),
    .timeout_err(timeout_err),
    .err_count(err_count),
    .dbg_state(dbg_state)
  );

  // clock and cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // datapath model: finish rises model_delay cycles after dp_mode leaves 0
  initial begin
    dp_finish = 1'b0;
    forever begin
      @(negedge clk);
      if (dp_force) begin
        dp_finish = 1'b1;
      end else if (dp_mode == 2'd0) begin
        mcnt = 0;
        dp_finish = 1'b0;
      end else begin
        mcnt++;
        if (model_en && (mcnt == model_delay)) dp_finish = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_wr(input logic [MS-1:0] msg, output int t_acc, output bit ok);
    ok = 0;
    t_acc = -1;
    wr_valid = 1'b1;
    wr_data = msg;
    for (int i = 0; i < 200 && !ok; i++) begin
      #1;
      if (wr_ready) begin
        ok = 1;
        t_acc = cyc;
      end
      @(negedge clk);
    end
    wr_valid = 1'b0;
  endtask

  task automatic send_rd(input logic [DW-1:0] strand, output int t_acc, output bit ok);
    ok = 0;
    t_acc = -1;
    rd_valid = 1'b1;
    rd_data = strand;
    for (int i = 0; i < 200 && !ok; i++) begin
      #1;
      if (rd_ready) begin
        ok = 1;
        t_acc = cyc;
      end
      @(negedge clk);
    end
    rd_valid = 1'b0;
  endtask

  task automatic wait_valid(input bit is_dec, input int budget, output int t_val, output bit ok);
    ok = 0;
    t_val = -1;
    for (int i = 0; i < budget && !ok; i++) begin
      if ((is_dec && dec_valid) || (!is_dec && enc_valid)) begin
        ok = 1;
        t_val = cyc;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic pulse_enc_ready();
    enc_ready = 1'b1;
    @(negedge clk);
    enc_ready = 1'b0;
  endtask

  task automatic pulse_dec_ready();
    dec_ready = 1'b1;
    @(negedge clk);
    dec_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetN = 1'b0;
    wr_valid = 1'b1;
    wr_data = M1;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_vec++; if (dp_mode !== 2'd0) begin n_err++; $display("FAIL reset_dp_mode: got %0d expected 0", dp_mode); end
    n_vec++; if (wr_ready !== 1'b0 || rd_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got wr=%0b rd=%0b expected 0 0", wr_ready, rd_ready); end
    n_vec++; if (enc_valid !== 1'b0 || dec_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got enc=%0b dec=%0b expected 0 0", enc_valid, dec_valid); end
    n_vec++; if (enc_data !== '0 || dec_data !== '0) begin n_err++; $display("FAIL reset_result_data: got enc=%0h dec=%0h expected 0", enc_data, dec_data); end
    n_vec++; if (dp_write_in !== '0 || dp_read_in !== '0) begin n_err++; $display("FAIL reset_operands: got w=%0h r=%0h expected 0", dp_write_in, dp_read_in); end
    n_vec++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_status: got busy=%0b to=%0b expected 0 0", busy, timeout_err); end
    n_vec++; if (err_count !== 16'd0) begin n_err++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
    n_vec++; if (dbg_state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0 (IDLE)", dbg_state); end
    wr_valid = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_encode();
    int t_acc, t_val;
    bit ok, vok, mode_bad, dec_seen;
    model_en = 1;
    model_delay = 5;
    dp_write_out = S1;
    send_wr(M1, t_acc, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL enc_accept: got no accept expected accept"); end
    n_vec++; if (dp_write_in !== M1) begin n_err++; $display("FAIL enc_operand: got %0h expected %0h", dp_write_in, M1); end
    vok = 0; mode_bad = 0; dec_seen = 0; t_val = -1;
    for (int i = 0; i < 30 && !vok; i++) begin
      if (dec_valid) dec_seen = 1;
      if (enc_valid) begin
        vok = 1;
        t_val = cyc;
      end else begin
        if (dp_mode !== 2'd1) mode_bad = 1;
        @(negedge clk);
      end
    end
    n_vec++; if (!vok) begin n_err++; $display("FAIL enc_result_timeout: got no enc_valid expected enc_valid"); end
    n_vec++; if (t_val - t_acc != 6) begin n_err++; $display("FAIL enc_latency: got %0d expected 6", t_val - t_acc); end
    n_vec++; if (enc_data !== S1) begin n_err++; $display("FAIL enc_data: got %0h expected %0h", enc_data, S1); end
    n_vec++; if (dp_mode !== 2'd0) begin n_err++; $display("FAIL enc_respond_mode: got %0d expected 0", dp_mode); end
    n_vec++; if (mode_bad) begin n_err++; $display("FAIL enc_mode_seq: got mode!=1 while busy expected 1"); end
    n_vec++; if (dec_seen) begin n_err++; $display("FAIL enc_dec_valid: got dec_valid=1 expected 0"); end
    pulse_enc_ready();
    n_vec++; if (busy !== 1'b1 || dp_mode !== 2'd0 || enc_valid !== 1'b0) begin n_err++; $display("FAIL enc_gap: got busy=%0b mode=%0d ev=%0b expected 1 0 0", busy, dp_mode, enc_valid); end
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL enc_idle: got busy=%0b expected 0", busy); end
  endtask

  task automatic test_tie_arbitration();
    logic exp_q[$];
    logic got, e;
    int grants, enc_n, dec_n;
    bit both_hi, data_bad;
    resetN = 1'b0;
    wr_valid = 1'b1; wr_data = M2;
    rd_valid = 1'b1; rd_data = S2;
    enc_ready = 1'b1; dec_ready = 1'b1;
    model_en = 1; model_delay = 2;
    dp_write_out = S1; dp_read_out = M1;
    @(negedge clk);
    #1;
    n_vec++; if (wr_ready !== 1'b0 || rd_ready !== 1'b0) begin n_err++; $display("FAIL tie_ready_in_reset: got wr=%0b rd=%0b expected 0 0", wr_ready, rd_ready); end
    @(negedge clk);
    resetN = 1'b1;
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    grants = 0; enc_n = 0; dec_n = 0; both_hi = 0; data_bad = 0;
    for (int i = 0; i < 200 && grants < 4; i++) begin
      #1;
      if (wr_ready && rd_ready) both_hi = 1;
      if (wr_ready || rd_ready) begin
        got = rd_ready;
        e = exp_q.pop_front();
        n_vec++; if (got !== e) begin n_err++; $display("FAIL tie_grant_%0d: got %s expected %s", grants, got ? "read" : "write", e ? "read" : "write"); end
        grants++;
      end
      if (enc_valid) begin enc_n++; if (enc_data !== S1) data_bad = 1; end
      if (dec_valid) begin dec_n++; if (dec_data !== M1) data_bad = 1; end
      @(negedge clk);
    end
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    n_vec++; if (grants != 4) begin n_err++; $display("FAIL tie_grant_count: got %0d expected 4", grants); end
    n_vec++; if (both_hi) begin n_err++; $display("FAIL tie_both_ready: got both high expected never"); end
    n_vec++; if (data_bad) begin n_err++; $display("FAIL tie_result_data: got wrong result data expected model data"); end
    n_vec++; if (enc_n != 2 || dec_n != 1) begin n_err++; $display("FAIL tie_results: got enc=%0d dec=%0d expected 2 1", enc_n, dec_n); end
    repeat (10) @(negedge clk);
    enc_ready = 1'b0;
    dec_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stale_finish();
    int t_acc;
    bit ok;
    dp_force = 1;
    dp_write_out = S2;
    @(negedge clk);
    @(negedge clk);
    send_wr(M1, t_acc, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL stale_accept: got no accept expected accept"); end
    n_vec++; if (dp_mode !== 2'd1 || enc_valid !== 1'b0) begin n_err++; $display("FAIL stale_arm: got mode=%0d ev=%0b expected 1 0", dp_mode, enc_valid); end
    @(negedge clk);
    n_vec++; if (dp_mode !== 2'd1 || enc_valid !== 1'b0) begin n_err++; $display("FAIL stale_wait: got mode=%0d ev=%0b expected 1 0", dp_mode, enc_valid); end
    @(negedge clk);
    n_vec++; if (enc_valid !== 1'b1 || cyc - t_acc != 3) begin n_err++; $display("FAIL stale_latency: got ev=%0b lat=%0d expected 1 3", enc_valid, cyc - t_acc); end
    n_vec++; if (enc_data !== S2) begin n_err++; $display("FAIL stale_data: got %0h expected %0h", enc_data, S2); end
    dp_force = 0;
    pulse_enc_ready();
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int t_acc, t_val, r;
    bit ok, vok, stable_bad;
    model_en = 1; model_delay = 2;
    dp_write_out = S1; dp_read_out = M2;
    send_wr(M2, t_acc, ok);
    wait_valid(1'b0, 20, t_val, vok);
    n_vec++; if (!ok || !vok) begin n_err++; $display("FAIL bp_first_op: got acc=%0b val=%0b expected 1 1", ok, vok); end
    rd_valid = 1'b1;
    rd_data = S2;
    stable_bad = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (!enc_valid || enc_data !== S1 || rd_ready || wr_ready) stable_bad = 1;
      @(negedge clk);
    end
    n_vec++; if (stable_bad) begin n_err++; $display("FAIL bp_hold: got unstable result or accept expected stable"); end
    r = cyc;
    pulse_enc_ready();
    #1;
    n_vec++; if (dp_mode !== 2'd0 || rd_ready !== 1'b0 || busy !== 1'b1 || enc_valid !== 1'b0) begin n_err++; $display("FAIL bp_gap: got mode=%0d rr=%0b busy=%0b ev=%0b expected 0 0 1 0", dp_mode, rd_ready, busy, enc_valid); end
    @(negedge clk);
    #1;
    n_vec++; if (rd_ready !== 1'b1 || cyc != r + 2) begin n_err++; $display("FAIL bp_next_accept: got rr=%0b at R+%0d expected 1 at R+2", rd_ready, cyc - r); end
    t_acc = cyc;
    @(negedge clk);
    rd_valid = 1'b0;
    n_vec++; if (dp_mode !== 2'd2 || dp_read_in !== S2) begin n_err++; $display("FAIL bp_read_arm: got mode=%0d op=%0h expected 2 %0h", dp_mode, dp_read_in, S2); end
    wait_valid(1'b1, 20, t_val, vok);
    n_vec++; if (!vok || t_val - t_acc != 3) begin n_err++; $display("FAIL bp_read_latency: got val=%0b lat=%0d expected 1 3", vok, t_val - t_acc); end
    n_vec++; if (dec_data !== M2) begin n_err++; $display("FAIL bp_read_data: got %0h expected %0h", dec_data, M2); end
    pulse_dec_ready();
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int t_acc, pulses, t_first;
    bit ok, enc_seen, gap_ok, idle_ok;
    model_en = 0;
    dp_write_out = S1;
    send_wr(M1, t_acc, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL to_accept: got no accept expected accept"); end
    pulses = 0; t_first = -1; enc_seen = 0; gap_ok = 0; idle_ok = 0;
    for (int i = 0; i < 22; i++) begin
      if (timeout_err) begin
        pulses++;
        if (t_first < 0) t_first = cyc;
      end
      if (enc_valid) enc_seen = 1;
      if (cyc == t_acc + 18) gap_ok = busy && (dp_mode == 2'd0);
      if (cyc == t_acc + 19) idle_ok = !busy;
      @(negedge clk);
    end
    n_vec++; if (t_first - t_acc != 17) begin n_err++; $display("FAIL to_time: got T+%0d expected T+17", t_first - t_acc); end
    n_vec++; if (pulses != 1) begin n_err++; $display("FAIL to_pulses: got %0d expected 1", pulses); end
    n_vec++; if (err_count !== 16'd1) begin n_err++; $display("FAIL to_err_count: got %0d expected 1", err_count); end
    n_vec++; if (enc_seen) begin n_err++; $display("FAIL to_no_result: got enc_valid expected none"); end
    n_vec++; if (!gap_ok || !idle_ok) begin n_err++; $display("FAIL to_gap_idle: got gap=%0b idle=%0b expected 1 1", gap_ok, idle_ok); end
  endtask

  task automatic test_reset_in_wait();
    int t_acc, t_val;
    bit ok, vok, dec_seen;
    model_en = 1; model_delay = 10;
    dp_read_out = M1;
    send_rd(S1, t_acc, ok);
    repeat (3) @(negedge clk);
    n_vec++; if (!ok || dp_mode !== 2'd2) begin n_err++; $display("FAIL rw_inflight: got acc=%0b mode=%0d expected 1 2", ok, dp_mode); end
    resetN = 1'b0;
    #1;
    n_vec++; if (dp_mode !== 2'd0 || busy !== 1'b0 || timeout_err !== 1'b0) begin n_err++; $display("FAIL rw_ctrl_zero: got mode=%0d busy=%0b to=%0b expected 0", dp_mode, busy, timeout_err); end
    n_vec++; if (dp_read_in !== '0 || dp_write_in !== '0) begin n_err++; $display("FAIL rw_operands_zero: got r=%0h w=%0h expected 0", dp_read_in, dp_write_in); end
    n_vec++; if (enc_data !== '0 || dec_data !== '0 || dec_valid !== 1'b0) begin n_err++; $display("FAIL rw_results_zero: got enc=%0h dec=%0h dv=%0b expected 0", enc_data, dec_data, dec_valid); end
    n_vec++; if (err_count !== 16'd0) begin n_err++; $display("FAIL rw_err_count: got %0d expected 0", err_count); end
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    model_delay = 3;
    dp_write_out = S2;
    dec_seen = 0;
    send_wr(M2, t_acc, ok);
    for (int i = 0; i < 20 && !enc_valid; i++) begin
      if (dec_valid) dec_seen = 1;
      @(negedge clk);
    end
    wait_valid(1'b0, 1, t_val, vok);
    n_vec++; if (!ok || !vok || t_val - t_acc != 4) begin n_err++; $display("FAIL rw_new_op: got acc=%0b val=%0b lat=%0d expected 1 1 4", ok, vok, t_val - t_acc); end
    n_vec++; if (enc_data !== S2) begin n_err++; $display("FAIL rw_new_data: got %0h expected %0h", enc_data, S2); end
    n_vec++; if (dec_seen) begin n_err++; $display("FAIL rw_dropped_op: got dec_valid expected none"); end
    pulse_enc_ready();
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    resetN = 1'b0;
    wr_valid = 1'b0; wr_data = '0;
    rd_valid = 1'b0; rd_data = '0;
    enc_ready = 1'b0; dec_ready = 1'b0;
    dp_write_out = '0; dp_read_out = '0;
    test_reset();
    test_single_encode();
    test_tie_arbitration();
    test_stale_finish();
    test_backpressure();
    test_timeout();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
